vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: divides clk down to a pixel tick, runs HC/VC and
// registers VIDON/HSYNC/VSYNC/PIX_EN/LINE_START/FRAME_START from the next counts.
module vga_sync_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       vidon,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Window edges kept 11 bits wide so an end value of 1024 still compares correctly.
  localparam logic [10:0] H_VIS_E  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_E  = 11'(V_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end
  endgenerate

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          h_wrap;
  logic [9:0]    hc_nxt;
  logic [9:0]    vc_nxt;
  logic [10:0]   hc_nxt_e;
  logic [10:0]   vc_nxt_e;

  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    h_wrap = (hc == H_LAST);
    hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
    vc_nxt = vc;
    if (h_wrap) begin
      vc_nxt = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
    hc_nxt_e = {1'b0, hc_nxt};
    vc_nxt_e = {1'b0, vc_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      hc          <= H_LAST;
      vc          <= V_LAST;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vidon       <= 1'b0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        hc          <= hc_nxt;
        vc          <= vc_nxt;
        pix_en      <= 1'b1;
        line_start  <= (hc_nxt == 10'd0);
        frame_start <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
        vidon       <= (hc_nxt_e < H_VIS_E) && (vc_nxt_e < V_VIS_E);
        hsync       <= ((hc_nxt_e >= HS_START) && (hc_nxt_e < HS_END)) ? HS_ACT : ~HS_ACT;
        vsync       <= ((vc_nxt_e >= VS_START) && (vc_nxt_e < VS_END)) ? VS_ACT : ~VS_ACT;
      end else begin
        pix_en      <= 1'b0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a raster model pushes expected per-tick outputs, monitors pop
// and compare. DUT 0 uses default 640x480 timing, DUT 1 a tiny raster at CLK_DIV=1.
module tb_vga_sync_gen;

  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, hp, vp, dv;
  } cfg_t;

  typedef struct {
    int k;
    int cyc;
    int hc;
    int vc;
    bit vid, hsy, vsy, ls, fs;
  } exp_t;

  logic       clk;
  logic       rstn [2];
  logic       pe   [2];
  logic [9:0] hcv  [2];
  logic [9:0] vcv  [2];
  logic       vid  [2];
  logic       hsy  [2];
  logic       vsy  [2];
  logic       lsv  [2];
  logic       fsv  [2];

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc     [2];
  int last_hc [2];
  int last_vc [2];
  int fs_last [2];
  int vid_cnt;
  int vs_cnt;

  vga_sync_gen u_dut0 (
    .clk(clk), .rst_n(rstn[0]), .pix_en(pe[0]), .hc(hcv[0]), .vc(vcv[0]),
    .vidon(vid[0]), .hsync(hsy[0]), .vsync(vsy[0]),
    .line_start(lsv[0]), .frame_start(fsv[0])
  );

  vga_sync_gen #(
    .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1), .VS_POL(0), .CLK_DIV(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rstn[1]), .pix_en(pe[1]), .hc(hcv[1]), .vc(vcv[1]),
    .vidon(vid[1]), .hsync(hsy[1]), .vsync(vsy[1]),
    .line_start(lsv[1]), .frame_start(fsv[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cfg_t get_cfg(input int d);
    cfg_t c;
    if (d == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
    else        c = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1, 0, 1};
    return c;
  endfunction

  function automatic int h_tot(input int d);
    cfg_t c = get_cfg(d);
    return c.hv + c.hf + c.hs + c.hb;
  endfunction

  function automatic int v_tot(input int d);
    cfg_t c = get_cfg(d);
    return c.vv + c.vf + c.vs + c.vb;
  endfunction

  // Tick k (1-based after release) lands on raster position k-1, on clock edge k*CLK_DIV.
  function automatic exp_t model(input int d, input int k);
    cfg_t c = get_cfg(d);
    exp_t e;
    int ht = h_tot(d);
    int p  = (k - 1) % (ht * v_tot(d));
    e.k   = k;
    e.cyc = k * c.dv;
    e.hc  = p % ht;
    e.vc  = p / ht;
    e.vid = (e.hc < c.hv) && (e.vc < c.vv);
    e.hsy = ((e.hc >= c.hv + c.hf) && (e.hc < c.hv + c.hf + c.hs)) ? (c.hp != 0) : (c.hp == 0);
    e.vsy = ((e.vc >= c.vv + c.vf) && (e.vc < c.vv + c.vf + c.vs)) ? (c.vp != 0) : (c.vp == 0);
    e.ls  = (e.hc == 0);
    e.fs  = (p == 0);
    return e;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(input int d);
    exp_t e;
    cfg_t c = get_cfg(d);
    bit   due;
    if (!rstn[d]) begin
      cyc[d]     = 0;
      last_hc[d] = h_tot(d) - 1;
      last_vc[d] = v_tot(d) - 1;
      fs_last[d] = -1;
      return;
    end
    cyc[d]++;
    due = 1'b0;
    if (qsize(d) > 0) begin
      e   = (d == 0) ? q0[0] : q1[0];
      due = (e.cyc == cyc[d]);
    end
    checks++;
    if (due) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      if (pe[d] !== 1'b1 || hcv[d] !== 10'(e.hc) || vcv[d] !== 10'(e.vc) ||
          vid[d] !== e.vid || hsy[d] !== e.hsy || vsy[d] !== e.vsy ||
          lsv[d] !== e.ls || fsv[d] !== e.fs) begin
        errors++;
        $display("FAIL tick d%0d k%0d cyc%0d: got pe=%b hc=%0d vc=%0d vid=%b hs=%b vs=%b ls=%b fs=%b want pe=1 hc=%0d vc=%0d vid=%b hs=%b vs=%b ls=%b fs=%b",
                 d, e.k, cyc[d], pe[d], hcv[d], vcv[d], vid[d], hsy[d], vsy[d], lsv[d], fsv[d],
                 e.hc, e.vc, e.vid, e.hsy, e.vsy, e.ls, e.fs);
      end
      last_hc[d] = e.hc;
      last_vc[d] = e.vc;
      if (d == 1 && e.k <= h_tot(1) * v_tot(1)) begin
        vid_cnt += int'(vid[1]);
        vs_cnt  += int'(vsy[1] == 1'b0);
      end
    end else begin
      if (pe[d] !== 1'b0 || lsv[d] !== 1'b0 || fsv[d] !== 1'b0 ||
          hcv[d] !== 10'(last_hc[d]) || vcv[d] !== 10'(last_vc[d])) begin
        errors++;
        $display("FAIL idle d%0d cyc%0d: got pe=%b ls=%b fs=%b hc=%0d vc=%0d want pe=0 ls=0 fs=0 hc=%0d vc=%0d",
                 d, cyc[d], pe[d], lsv[d], fsv[d], hcv[d], vcv[d], last_hc[d], last_vc[d]);
      end
    end
    if (fsv[d] === 1'b1) begin
      if (fs_last[d] >= 0) begin
        checks++;
        if (cyc[d] - fs_last[d] != h_tot(d) * v_tot(d) * c.dv) begin
          errors++;
          $display("FAIL frame_gap d%0d: got %0d cycles want %0d",
                   d, cyc[d] - fs_last[d], h_tot(d) * v_tot(d) * c.dv);
        end
      end
      fs_last[d] = cyc[d];
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called with no clock edge since reset asserted: checks the asynchronous reset path.
  task automatic chk_reset(input int d, input string tag);
    cfg_t c = get_cfg(d);
    checks++;
    if (hcv[d] !== 10'(h_tot(d) - 1) || vcv[d] !== 10'(v_tot(d) - 1) ||
        pe[d] !== 1'b0 || lsv[d] !== 1'b0 || fsv[d] !== 1'b0 || vid[d] !== 1'b0 ||
        hsy[d] !== (c.hp == 0) || vsy[d] !== (c.vp == 0)) begin
      errors++;
      $display("FAIL reset_%s d%0d: got hc=%0d vc=%0d pe=%b ls=%b fs=%b vid=%b hs=%b vs=%b want hc=%0d vc=%0d pe=0 ls=0 fs=0 vid=0 hs=%b vs=%b",
               tag, d, hcv[d], vcv[d], pe[d], lsv[d], fsv[d], vid[d], hsy[d], vsy[d],
               h_tot(d) - 1, v_tot(d) - 1, c.hp == 0, c.vp == 0);
    end
  endtask

  task automatic run(input int d, input int n);
    cfg_t c = get_cfg(d);
    int budget;
    for (int k = 1; k <= n; k++) begin
      if (d == 0) q0.push_back(model(d, k)); else q1.push_back(model(d, k));
    end
    @(negedge clk);
    #2 rstn[d] = 1'b1;
    budget = n * c.dv + 20;
    while (qsize(d) > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (qsize(d) > 0) begin
      errors++;
      $display("FAIL timeout d%0d: got %0d ticks pending want 0", d, qsize(d));
      if (d == 0) q0.delete(); else q1.delete();
    end
    #2 rstn[d] = 1'b0;
    #1 chk_reset(d, "mid");
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  initial begin
    rstn[0] = 1'b0;
    rstn[1] = 1'b0;
    vid_cnt = 0;
    vs_cnt  = 0;
    repeat (3) @(posedge clk);
    #3;
    chk_reset(0, "init");
    chk_reset(1, "init");

    run(0, 11 * 800 + 700);
    run(0, $urandom_range(1, 1600));

    vid_cnt = 0;
    vs_cnt  = 0;
    run(1, 3 * h_tot(1) * v_tot(1) + $urandom_range(0, 175));
    checks++;
    if (vid_cnt != S_HV * S_VV) begin
      errors++;
      $display("FAIL vidon_ticks: got %0d want %0d", vid_cnt, S_HV * S_VV);
    end
    checks++;
    if (vs_cnt != S_VS * h_tot(1)) begin
      errors++;
      $display("FAIL vsync_ticks: got %0d want %0d", vs_cnt, S_VS * h_tot(1));
    end

    repeat (3) run(1, $urandom_range(1, 400));
    run(0, $urandom_range(1, 900));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
